// File: rtl/fm_wm_pingpong_buffer_if.sv
// Producer/consumer bus for the ping-pong row buffer: a write row channel, a read row channel,
// and a read-only debug view of the bank pointers and bank states.
interface fm_wm_pingpong_buffer_if #(
   parameter int ROWS       = 6,
   parameter int COLS       = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ROW_WIDTH  = $clog2(ROWS)
);
   // Handshake: a write is accepted on a clock edge where wr_en && wr_ready, and a read request
   // is accepted on a clock edge where rd_en && rd_avail. wr_ready and rd_avail depend only on
   // registered state, never on wr_en or rd_en. An accepted read returns its row one cycle later
   // with rd_valid=1. wr_last/rd_last act only together with an accepted transfer.
   logic                         wr_en;
   logic [ROW_WIDTH-1:0]         wr_row;
   logic                         wr_acc;
   logic                         wr_last;
   logic signed [DATA_WIDTH-1:0] wr_data [0:COLS-1];
   logic                         wr_ready;

   logic                         rd_en;
   logic [ROW_WIDTH-1:0]         rd_row;
   logic                         rd_last;
   logic                         rd_avail;
   logic signed [DATA_WIDTH-1:0] rd_data [0:COLS-1];
   logic                         rd_valid;

   logic                         dbg_wb;
   logic                         dbg_rb;
   logic [1:0]                   dbg_full;

   modport master (
      output wr_en, wr_row, wr_acc, wr_last, wr_data,
      output rd_en, rd_row, rd_last,
      input  wr_ready, rd_avail, rd_data, rd_valid,
      input  dbg_wb, dbg_rb, dbg_full
   );

   modport slave (
      input  wr_en, wr_row, wr_acc, wr_last, wr_data,
      input  rd_en, rd_row, rd_last,
      output wr_ready, rd_avail, rd_data, rd_valid,
      output dbg_wb, dbg_rb, dbg_full
   );
endinterface

// File: rtl/fm_wm_pingpong_buffer.sv
// Two-bank row buffer: the producer fills (optionally saturating-accumulates) one bank while
// the consumer drains the other; banks swap on wr_last / rd_last.
module fm_wm_pingpong_buffer #(
   parameter int ROWS       = 6,
   parameter int COLS       = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ROW_WIDTH  = $clog2(ROWS)
) (
   input  logic                   clk,
   input  logic                   rst,
   fm_wm_pingpong_buffer_if.slave bus,
   output logic                   ovf_flag,
   output logic                   err_flag,
   input  logic                   err_clr
);
   localparam logic [ROW_WIDTH:0] ROWS_L = ROWS[ROW_WIDTH:0];
   localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH-1:0] mem [2][ROWS][COLS];
   logic [ROWS-1:0]              written [2];
   logic [1:0]                   full;
   logic                         wb;
   logic                         rb;

   logic                         wr_ready;
   logic                         rd_avail;
   logic                         wr_in_range;
   logic                         rd_in_range;
   logic                         wr_accept;
   logic                         wr_ok;
   logic                         rd_accept;
   logic                         any_sat;
   logic                         new_err;
   logic signed [DATA_WIDTH-1:0] base_v  [COLS];
   logic signed [DATA_WIDTH:0]   sum_v   [COLS];
   logic signed [DATA_WIDTH-1:0] new_row [COLS];

   assign wr_ready     = ~full[wb];
   assign rd_avail     = full[rb];
   assign bus.wr_ready = wr_ready;
   assign bus.rd_avail = rd_avail;
   assign bus.dbg_wb   = wb;
   assign bus.dbg_rb   = rb;
   assign bus.dbg_full = full;

   always_comb begin
      wr_in_range = {1'b0, bus.wr_row} < ROWS_L;
      rd_in_range = {1'b0, bus.rd_row} < ROWS_L;
      wr_accept   = bus.wr_en && wr_ready;
      wr_ok       = wr_accept && wr_in_range;
      rd_accept   = bus.rd_en && rd_avail;
      any_sat     = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         // Rows never written since the bank was released accumulate onto zero, not stale data.
         base_v[c]  = (wr_in_range && written[wb][bus.wr_row]) ? mem[wb][bus.wr_row][c] : '0;
         sum_v[c]   = {base_v[c][DATA_WIDTH-1], base_v[c]}
                    + {bus.wr_data[c][DATA_WIDTH-1], bus.wr_data[c]};
         new_row[c] = bus.wr_data[c];
         if (bus.wr_acc) begin
            if (sum_v[c][DATA_WIDTH] != sum_v[c][DATA_WIDTH-1]) begin
               new_row[c] = sum_v[c][DATA_WIDTH] ? SAT_MIN : SAT_MAX;
               any_sat    = 1'b1;
            end else begin
               new_row[c] = sum_v[c][DATA_WIDTH-1:0];
            end
         end
      end
      new_err = (bus.wr_en && !wr_ready) || (wr_accept && !wr_in_range)
             || (bus.rd_en && !rd_avail) || (rd_accept && !rd_in_range);
   end

   // Row storage carries no reset; the written bits mask whatever it holds.
   always_ff @(posedge clk) begin
      if (rst && wr_ok) begin
         for (int c = 0; c < COLS; c++) mem[wb][bus.wr_row][c] <= new_row[c];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb           <= 1'b0;
         rb           <= 1'b0;
         full         <= 2'b00;
         written[0]   <= '0;
         written[1]   <= '0;
         bus.rd_valid <= 1'b0;
         for (int c = 0; c < COLS; c++) bus.rd_data[c] <= '0;
         ovf_flag     <= 1'b0;
         err_flag     <= 1'b0;
      end else begin
         bus.rd_valid <= rd_accept;
         if (rd_accept) begin
            for (int c = 0; c < COLS; c++) begin
               bus.rd_data[c] <= (rd_in_range && written[rb][bus.rd_row])
                               ? mem[rb][bus.rd_row][c] : '0;
            end
            if (bus.rd_last) begin
               full[rb]    <= 1'b0;
               written[rb] <= '0;
               rb          <= ~rb;
            end
         end
         // A write needs wb FREE and a read needs rb FULL, so both paths never touch one bank.
         if (wr_ok) written[wb][bus.wr_row] <= 1'b1;
         if (wr_accept && bus.wr_last) begin
            full[wb] <= 1'b1;
            wb       <= ~wb;
         end
         ovf_flag <= (ovf_flag && !err_clr) || (wr_ok && any_sat);
         err_flag <= (err_flag && !err_clr) || new_err;
      end
   end
endmodule
